noc_eject_buffer: RTL and testbench



---
 rtl/noc_eject_buffer_if.sv | 31 +++
 rtl/noc_eject_buffer.sv | 127 ++++++++++++
 tb/tb_noc_eject_buffer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/noc_eject_buffer_if.sv
// Ejection link bundle: router send/credit side plus AXI-Stream side.
// The master view is the environment (router + consumer); the slave view is the eject buffer.
interface noc_eject_buffer_if #(
  parameter int TDATA_WIDTH = 64,
  parameter int TID_WIDTH   = 2,
  parameter int TDEST_WIDTH = 4,
  parameter int DEST_WIDTH  = TID_WIDTH + TDEST_WIDTH
);
  logic [TDATA_WIDTH-1:0] data_in;
  logic [DEST_WIDTH-1:0]  dest_in;
  logic                   is_tail_in;
  logic                   send_in;
  logic                   credit_out;

  logic                   axis_tvalid;
  logic                   axis_tready;
  logic [TDATA_WIDTH-1:0] axis_tdata;
  logic                   axis_tlast;
  logic [TID_WIDTH-1:0]   axis_tid;
  logic [TDEST_WIDTH-1:0] axis_tdest;

  modport master (
    output data_in, dest_in, is_tail_in, send_in, axis_tready,
    input  credit_out, axis_tvalid, axis_tdata, axis_tlast, axis_tid, axis_tdest
  );

  modport slave (
    input  data_in, dest_in, is_tail_in, send_in, axis_tready,
    output credit_out, axis_tvalid, axis_tdata, axis_tlast, axis_tid, axis_tdest
  );
endinterface

// File: rtl/noc_eject_buffer.sv
// NoC ejection buffer: flit FIFO feeding an AXI-Stream master, one credit per popped flit,
// delivered-packet counter and sticky overflow / framing error flags.
module noc_eject_buffer #(
  parameter int TDATA_WIDTH   = 64,
  parameter int TID_WIDTH     = 2,
  parameter int TDEST_WIDTH   = 4,
  parameter int DEST_WIDTH    = TID_WIDTH + TDEST_WIDTH,
  parameter int BUFFER_DEPTH  = 2,
  parameter int PKT_CNT_WIDTH = 16
) (
  input  logic                     clk_noc,
  input  logic                     rst_noc_sync,
  noc_eject_buffer_if.slave        bus,
  output logic [PKT_CNT_WIDTH-1:0] pkt_count,
  output logic                     overflow_err,
  output logic                     frame_err
);

  localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int OCC_W = $clog2(BUFFER_DEPTH + 1);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(BUFFER_DEPTH);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } frame_state_e;

  logic [TDATA_WIDTH-1:0] data_mem [BUFFER_DEPTH];
  logic [DEST_WIDTH-1:0]  dest_mem [BUFFER_DEPTH];
  logic                   tail_mem [BUFFER_DEPTH];

  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]         occ_q, occ_d;
  logic                     credit_q;
  logic [PKT_CNT_WIDTH-1:0] pkt_count_q;
  logic                     overflow_q, frame_err_q;
  frame_state_e             state_q, state_d;
  logic [DEST_WIDTH-1:0]    pkt_dest_q, pkt_dest_d;

  logic push, pop, drop, dest_mismatch;

  // A full buffer still accepts a flit when the head leaves in the same cycle.
  assign pop  = (occ_q != '0) && bus.axis_tready;
  assign push = bus.send_in && ((occ_q != DEPTH_OCC) || pop);
  assign drop = bus.send_in && !push;

  always_comb begin
    occ_d = occ_q;
    if (push && !pop)      occ_d = occ_q + OCC_W'(1);
    else if (pop && !push) occ_d = occ_q - OCC_W'(1);
  end

  always_ff @(posedge clk_noc) begin
    if (push) begin
      data_mem[wr_ptr_q] <= bus.data_in;
      dest_mem[wr_ptr_q] <= bus.dest_in;
      tail_mem[wr_ptr_q] <= bus.is_tail_in;
    end
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      credit_q    <= 1'b0;
      pkt_count_q <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q    <= occ_d;
      credit_q <= pop;
      if (pop && tail_mem[rd_ptr_q]) pkt_count_q <= pkt_count_q + PKT_CNT_WIDTH'(1);
      if (drop)          overflow_q  <= 1'b1;
      if (dest_mismatch) frame_err_q <= 1'b1;
    end
  end

  // Framing FSM, observes accepted flits only (dropped flits are invisible to it)
  // state  | meaning
  // IDLE   | between packets; next accepted flit starts a packet
  // IN_PKT | head accepted, waiting for tail; dest must match the latched one
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      state_q    <= IDLE;
      pkt_dest_q <= '0;
    end else begin
      state_q    <= state_d;
      pkt_dest_q <= pkt_dest_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pkt_dest_d    = pkt_dest_q;
    dest_mismatch = 1'b0;
    case (state_q)
      IDLE: begin
        if (push && !bus.is_tail_in) begin
          state_d    = IN_PKT;
          pkt_dest_d = bus.dest_in;
        end
      end
      IN_PKT: begin
        if (push) begin
          dest_mismatch = (bus.dest_in != pkt_dest_q);
          if (bus.is_tail_in) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.axis_tvalid = (occ_q != '0);
  assign bus.axis_tdata  = data_mem[rd_ptr_q];
  assign bus.axis_tlast  = tail_mem[rd_ptr_q];
  assign bus.axis_tid    = dest_mem[rd_ptr_q][DEST_WIDTH-1:TDEST_WIDTH];
  assign bus.axis_tdest  = dest_mem[rd_ptr_q][TDEST_WIDTH-1:0];
  assign bus.credit_out  = credit_q;

  assign pkt_count    = pkt_count_q;
  assign overflow_err = overflow_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_noc_eject_buffer.sv
// Directed bench for noc_eject_buffer: vector table for single-cycle behaviour plus
// hand sequences for reset mid-packet and sustained full-buffer streaming.
module tb_noc_eject_buffer;

  logic clk_noc = 1'b0;
  logic rst_noc_sync;
  logic [15:0] pkt_count;
  logic overflow_err, frame_err;

  int checks = 0;
  int failures = 0;

  noc_eject_buffer_if #(.TDATA_WIDTH(64), .TID_WIDTH(2), .TDEST_WIDTH(4), .DEST_WIDTH(6)) bus ();

  noc_eject_buffer #(
    .TDATA_WIDTH(64), .TID_WIDTH(2), .TDEST_WIDTH(4), .DEST_WIDTH(6),
    .BUFFER_DEPTH(2), .PKT_CNT_WIDTH(16)
  ) dut (
    .clk_noc      (clk_noc),
    .rst_noc_sync (rst_noc_sync),
    .bus          (bus),
    .pkt_count    (pkt_count),
    .overflow_err (overflow_err),
    .frame_err    (frame_err)
  );

  always #5 clk_noc = ~clk_noc;

  typedef struct {
    int          send;
    logic [63:0] data;
    int          dest;
    int          tail;
    int          tready;
    int          e_valid;
    logic [63:0] e_data;
    int          e_last;
    int          e_tid;
    int          e_tdest;
    int          e_credit;
    int          e_pkt;
    int          e_ovf;
    int          e_ferr;
  } vec_t;

  vec_t vecs [20];

  task automatic step();
    @(posedge clk_noc);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s idx=%0d got=%0h exp=%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input int send, input logic [63:0] data, input int dest, input int tail, input int tready);
    bus.send_in     = (send != 0);
    bus.data_in     = data;
    bus.dest_in     = 6'(dest);
    bus.is_tail_in  = (tail != 0);
    bus.axis_tready = (tready != 0);
  endtask

  task automatic chk_status(input int idx, input int valid, input int credit, input int pkt, input int ovf, input int ferr);
    chk("tvalid", idx, 64'(bus.axis_tvalid), 64'(valid));
    chk("credit", idx, 64'(bus.credit_out), 64'(credit));
    chk("pkt_count", idx, 64'(pkt_count), 64'(pkt));
    chk("overflow_err", idx, 64'(overflow_err), 64'(ovf));
    chk("frame_err", idx, 64'(frame_err), 64'(ferr));
  endtask

  task automatic chk_head(input int idx, input logic [63:0] data, input int last, input int tid, input int tdest);
    chk("tdata", idx, bus.axis_tdata, data);
    chk("tlast", idx, 64'(bus.axis_tlast), 64'(last));
    chk("tid", idx, 64'(bus.axis_tid), 64'(tid));
    chk("tdest", idx, 64'(bus.axis_tdest), 64'(tdest));
  endtask

  initial begin
    //          send data    dest tail rdy | vld edata   last tid tdest | cred pkt ovf ferr
    vecs[0]  = '{1, 64'hA5, 'h23, 1, 1,  1, 64'hA5, 1, 2, 3,  0, 0, 0, 0};
    vecs[1]  = '{0, 64'h0,  0,    0, 1,  0, 64'h0,  0, 0, 0,  1, 1, 0, 0};
    vecs[2]  = '{0, 64'h0,  0,    0, 1,  0, 64'h0,  0, 0, 0,  0, 1, 0, 0};
    vecs[3]  = '{1, 64'h11, 'h05, 0, 0,  1, 64'h11, 0, 0, 5,  0, 1, 0, 0};
    vecs[4]  = '{1, 64'h22, 'h05, 1, 0,  1, 64'h11, 0, 0, 5,  0, 1, 0, 0};
    vecs[5]  = '{0, 64'h0,  0,    0, 0,  1, 64'h11, 0, 0, 5,  0, 1, 0, 0};
    vecs[6]  = '{0, 64'h0,  0,    0, 1,  1, 64'h22, 1, 0, 5,  1, 1, 0, 0};
    vecs[7]  = '{0, 64'h0,  0,    0, 1,  0, 64'h0,  0, 0, 0,  1, 2, 0, 0};
    vecs[8]  = '{0, 64'h0,  0,    0, 1,  0, 64'h0,  0, 0, 0,  0, 2, 0, 0};
    vecs[9]  = '{1, 64'h33, 'h01, 1, 0,  1, 64'h33, 1, 0, 1,  0, 2, 0, 0};
    vecs[10] = '{1, 64'h44, 'h01, 1, 0,  1, 64'h33, 1, 0, 1,  0, 2, 0, 0};
    vecs[11] = '{1, 64'h55, 'h01, 1, 0,  1, 64'h33, 1, 0, 1,  0, 2, 1, 0};
    vecs[12] = '{0, 64'h0,  0,    0, 1,  1, 64'h44, 1, 0, 1,  1, 3, 1, 0};
    vecs[13] = '{0, 64'h0,  0,    0, 1,  0, 64'h0,  0, 0, 0,  1, 4, 1, 0};
    vecs[14] = '{0, 64'h0,  0,    0, 1,  0, 64'h0,  0, 0, 0,  0, 4, 1, 0};
    vecs[15] = '{1, 64'h61, 'h07, 0, 1,  1, 64'h61, 0, 0, 7,  0, 4, 1, 0};
    vecs[16] = '{1, 64'h62, 'h09, 0, 1,  1, 64'h62, 0, 0, 9,  1, 4, 1, 1};
    vecs[17] = '{1, 64'h63, 'h07, 1, 1,  1, 64'h63, 1, 0, 7,  1, 4, 1, 1};
    vecs[18] = '{0, 64'h0,  0,    0, 1,  0, 64'h0,  0, 0, 0,  1, 5, 1, 1};
    vecs[19] = '{0, 64'h0,  0,    0, 1,  0, 64'h0,  0, 0, 0,  0, 5, 1, 1};

    rst_noc_sync = 1'b1;
    drive(0, 64'h0, 0, 0, 0);
    step();
    step();
    chk_status(100, 0, 0, 0, 0, 0);
    rst_noc_sync = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].send, vecs[i].data, vecs[i].dest, vecs[i].tail, vecs[i].tready);
      step();
      chk_status(i, vecs[i].e_valid, vecs[i].e_credit, vecs[i].e_pkt, vecs[i].e_ovf, vecs[i].e_ferr);
      if (vecs[i].e_valid != 0)
        chk_head(i, vecs[i].e_data, vecs[i].e_last, vecs[i].e_tid, vecs[i].e_tdest);
    end

    // Reset with two flits of an open packet buffered and flags set
    drive(1, 64'h71, 'h05, 0, 0);
    step();
    drive(1, 64'h72, 'h05, 0, 0);
    step();
    chk_head(200, 64'h71, 0, 0, 5);
    drive(0, 64'h0, 0, 0, 1);
    rst_noc_sync = 1'b1;
    step();
    chk_status(201, 0, 0, 0, 0, 0);
    rst_noc_sync = 1'b0;
    step();
    chk_status(202, 0, 0, 0, 0, 0);
    step();
    chk_status(203, 0, 0, 0, 0, 0);
    drive(1, 64'h81, 'h2A, 1, 1);
    step();
    chk_status(204, 1, 0, 0, 0, 0);
    chk_head(204, 64'h81, 1, 2, 10);
    drive(0, 64'h0, 0, 0, 1);
    step();
    chk_status(205, 0, 1, 1, 0, 0);
    step();
    chk_status(206, 0, 0, 1, 0, 0);

    // Full buffer with simultaneous push and pop: 20 single-flit packets at 1 flit/cycle
    rst_noc_sync = 1'b1;
    drive(0, 64'h0, 0, 0, 0);
    step();
    rst_noc_sync = 1'b0;
    drive(1, 64'h100, 'h11, 1, 0);
    step();
    drive(1, 64'h101, 'h11, 1, 0);
    step();
    chk_status(300, 1, 0, 0, 0, 0);
    chk_head(300, 64'h100, 1, 1, 1);
    for (int j = 0; j < 18; j++) begin
      drive(1, 64'h102 + 64'(j), 'h11, 1, 1);
      step();
      chk_status(310 + j, 1, 1, j + 1, 0, 0);
      chk("stream_head", 310 + j, bus.axis_tdata, 64'h101 + 64'(j));
    end
    drive(0, 64'h0, 0, 0, 1);
    step();
    chk_status(330, 1, 1, 19, 0, 0);
    chk_head(330, 64'h113, 1, 1, 1);
    step();
    chk_status(331, 0, 1, 20, 0, 0);
    step();
    chk_status(332, 0, 0, 20, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
